// File: rtl/color_poly_correct_if.sv
// ----------------------------------------------------------------------------
// color_poly_correct_if
//   Bundles the pixel stream (input and output valid/ready beats) and the
//   coefficient programming bus of color_poly_correct.
//
//   Pixel in   : valid_i, ready_o, x_i, y_i, red_i, green_i, blue_i
//   Pixel out  : valid_o, ready_i, x_o, y_o, red_o, green_o, blue_o
//   Coef bus   : coef_we, coef_addr, coef_data, coef_commit,
//                commit_pending_o, active_bank_o
//
//   master : the side that drives pixels and coefficients (source/CPU side).
//   slave  : the correction block itself.
// ----------------------------------------------------------------------------
interface color_poly_correct_if #(
  parameter int PIX_W   = 8,
  parameter int COORD_W = 10,
  parameter int COEF_W  = 24
);
  logic               valid_i;
  logic               ready_o;
  logic [COORD_W-1:0] x_i;
  logic [COORD_W-1:0] y_i;
  logic [PIX_W-1:0]   red_i;
  logic [PIX_W-1:0]   green_i;
  logic [PIX_W-1:0]   blue_i;

  logic               valid_o;
  logic               ready_i;
  logic [COORD_W-1:0] x_o;
  logic [COORD_W-1:0] y_o;
  logic [PIX_W-1:0]   red_o;
  logic [PIX_W-1:0]   green_o;
  logic [PIX_W-1:0]   blue_o;

  logic               coef_we;
  logic [5:0]         coef_addr;
  logic [COEF_W-1:0]  coef_data;
  logic               coef_commit;
  logic               commit_pending_o;
  logic               active_bank_o;

  modport master (
    output valid_i, x_i, y_i, red_i, green_i, blue_i,
    output ready_i,
    output coef_we, coef_addr, coef_data, coef_commit,
    input  ready_o, valid_o, x_o, y_o, red_o, green_o, blue_o,
    input  commit_pending_o, active_bank_o
  );

  modport slave (
    input  valid_i, x_i, y_i, red_i, green_i, blue_i,
    input  ready_i,
    input  coef_we, coef_addr, coef_data, coef_commit,
    output ready_o, valid_o, x_o, y_o, red_o, green_o, blue_o,
    output commit_pending_o, active_bank_o
  );
endinterface

// File: rtl/color_poly_correct.sv
// ----------------------------------------------------------------------------
// color_poly_correct
//   Cubic-polynomial colour correction. Each output channel is
//   sum(coef[ch][t] * term[t]) over 18 monomials of R, G, B up to degree 3,
//   rounded, offset by AMB_SHIFT and clamped to pixel range.
//   Coefficients live in two banks: writes go to the shadow bank, and a
//   committed swap is applied when the (0,0) pixel is accepted.
//
//   Ports
//     clk_25 : pixel clock
//     reset  : asynchronous, active-low reset
//     bus    : color_poly_correct_if.slave (pixel in/out handshakes and
//              coefficient programming bus)
//
//   Pipeline: S1 terms -> S2 MAC -> S3 round/offset/clamp (output regs).
//   One global stall: every stage advances only when the output register is
//   empty or being drained.
// ----------------------------------------------------------------------------
module color_poly_correct #(
  parameter int                      PIX_W     = 8,
  parameter int                      COORD_W   = 10,
  parameter int                      COEF_W    = 24,
  parameter int                      FRAC_BITS = 16,
  parameter int                      ACC_W     = 56,
  parameter logic signed [PIX_W+1:0] AMB_SHIFT = '0
) (
  input logic                 clk_25,
  input logic                 reset,
  color_poly_correct_if.slave bus
);

  localparam int N_TERMS = 18;
  localparam int N_COEF  = 3 * N_TERMS;
  localparam int TERM_W  = 3 * PIX_W;
  localparam int PROD_W  = COEF_W + TERM_W + 1;

  localparam logic        [COEF_W-1:0] COEF_ONE   = COEF_W'(1) << FRAC_BITS;
  localparam logic        [5:0]        ADDR_LIMIT = 6'(N_COEF);
  localparam logic signed [ACC_W-1:0]  ROUND_HALF = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0]  PIX_MAX    = ACC_W'((64'd1 << PIX_W) - 64'd1);
  localparam logic signed [ACC_W-1:0]  AMB_EXT    = ACC_W'(AMB_SHIFT);

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic adv;
  logic accept;
  logic at_origin;
  logic swap;
  logic beat_bank;
  logic coef_wr_en;

  logic active_bank;
  logic commit_pending;
  logic out_valid;

  assign adv       = bus.ready_i || !out_valid;
  assign accept    = bus.valid_i && adv;
  assign at_origin = (bus.x_i == '0) && (bus.y_i == '0);

  // A commit arriving together with the (0,0) accept defers the swap to the
  // next frame start.
  assign swap       = accept && at_origin && commit_pending && !bus.coef_commit;
  assign beat_bank  = active_bank ^ swap;
  assign coef_wr_en = bus.coef_we && !commit_pending && (bus.coef_addr < ADDR_LIMIT);

  assign bus.ready_o          = adv;
  assign bus.commit_pending_o = commit_pending;
  assign bus.active_bank_o    = active_bank;

  // --------------------------------------------------------------------------
  // Bank control
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      active_bank    <= 1'b0;
      commit_pending <= 1'b0;
    end else if (swap) begin
      active_bank    <= ~active_bank;
      commit_pending <= 1'b0;
    end else if (bus.coef_commit) begin
      commit_pending <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Coefficient banks
  // A beat reads its coefficients in S2. No beat of the shadow bank can be
  // in flight when it is written: the swap accept advances the whole pipe
  // and writes are blocked while a swap is pending, so the bank a beat
  // carries is never modified before its MAC.
  // --------------------------------------------------------------------------
  logic [COEF_W-1:0] bank [2][N_COEF];

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < N_COEF; i++) begin
          // Identity: the linear self-term of each channel (15, 34, 53).
          bank[b[0]][i[5:0]] <= ((i % (N_TERMS + 1)) == 15) ? COEF_ONE : '0;
        end
      end
    end else if (coef_wr_en) begin
      bank[~active_bank][bus.coef_addr] <= bus.coef_data;
    end
  end

  // --------------------------------------------------------------------------
  // S1: exact unsigned monomials
  // --------------------------------------------------------------------------
  logic [TERM_W-1:0] cr, cg, cb, crr, cgg, cbb;
  logic [TERM_W-1:0] term [N_TERMS];

  always_comb begin
    cr  = TERM_W'(bus.red_i);
    cg  = TERM_W'(bus.green_i);
    cb  = TERM_W'(bus.blue_i);
    crr = cr * cr;
    cgg = cg * cg;
    cbb = cb * cb;
    term[0]  = crr * cr;
    term[1]  = cgg * cg;
    term[2]  = cbb * cb;
    term[3]  = crr * cg;
    term[4]  = cr * cgg;
    term[5]  = cgg * cb;
    term[6]  = cg * cbb;
    term[7]  = cbb * cr;
    term[8]  = cb * crr;
    term[9]  = crr;
    term[10] = cgg;
    term[11] = cbb;
    term[12] = cr * cg;
    term[13] = cg * cb;
    term[14] = cb * cr;
    term[15] = cr;
    term[16] = cg;
    term[17] = cb;
  end

  logic               s1_valid;
  logic               s1_bank;
  logic [COORD_W-1:0] s1_x;
  logic [COORD_W-1:0] s1_y;
  logic [TERM_W-1:0]  s1_term [N_TERMS];

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_bank  <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_term  <= '{default: '0};
    end else if (adv) begin
      s1_valid <= bus.valid_i;
      s1_bank  <= beat_bank;
      s1_x     <= bus.x_i;
      s1_y     <= bus.y_i;
      s1_term  <= term;
    end
  end

  // --------------------------------------------------------------------------
  // S2: signed multiply-accumulate per channel
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0]  mac [3];
  logic signed [PROD_W-1:0] prod;
  logic        [COEF_W-1:0] coef;
  int unsigned              cidx;

  always_comb begin
    prod = '0;
    coef = '0;
    cidx = 0;
    mac  = '{default: '0};
    for (int unsigned ch = 0; ch < 3; ch++) begin
      for (int unsigned t = 0; t < N_TERMS; t++) begin
        cidx = ch * N_TERMS + t;
        coef = bank[s1_bank][cidx[5:0]];
        prod = PROD_W'($signed(coef)) * PROD_W'($signed({1'b0, s1_term[t[4:0]]}));
        mac[ch[1:0]] = mac[ch[1:0]] + ACC_W'(prod);
      end
    end
  end

  logic               s2_valid;
  logic [COORD_W-1:0] s2_x;
  logic [COORD_W-1:0] s2_y;
  logic signed [ACC_W-1:0] s2_acc [3];

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_x     <= '0;
      s2_y     <= '0;
      s2_acc   <= '{default: '0};
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_x     <= s1_x;
      s2_y     <= s1_y;
      s2_acc   <= mac;
    end
  end

  // --------------------------------------------------------------------------
  // S3: round half-up, ambient offset, clamp
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0] rnd [3];
  logic signed [ACC_W-1:0] ofs [3];
  logic [PIX_W-1:0]        pix_next [3];

  always_comb begin
    rnd      = '{default: '0};
    ofs      = '{default: '0};
    pix_next = '{default: '0};
    for (int unsigned ch = 0; ch < 3; ch++) begin
      rnd[ch[1:0]] = (s2_acc[ch[1:0]] + ROUND_HALF) >>> FRAC_BITS;
      ofs[ch[1:0]] = rnd[ch[1:0]] + AMB_EXT;
      if (ofs[ch[1:0]][ACC_W-1]) begin
        pix_next[ch[1:0]] = '0;
      end else if (ofs[ch[1:0]] > PIX_MAX) begin
        pix_next[ch[1:0]] = '1;
      end else begin
        pix_next[ch[1:0]] = ofs[ch[1:0]][PIX_W-1:0];
      end
    end
  end

  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [PIX_W-1:0]   out_pix [3];

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_pix   <= '{default: '0};
    end else if (adv) begin
      out_valid <= s2_valid;
      out_x     <= s2_x;
      out_y     <= s2_y;
      out_pix   <= pix_next;
    end
  end

  assign bus.valid_o = out_valid;
  assign bus.x_o     = out_x;
  assign bus.y_o     = out_y;
  assign bus.red_o   = out_pix[0];
  assign bus.green_o = out_pix[1];
  assign bus.blue_o  = out_pix[2];

endmodule

// File: tb/tb_color_poly_correct.sv
// ----------------------------------------------------------------------------
// tb_color_poly_correct
//   Self-checking bench for color_poly_correct. A reference model computes
//   each beat's result from the polynomial definition (monomial exponent
//   tables, plain integer arithmetic) and tracks the 3-deep pipe occupancy,
//   bank state and commit state; every cycle the DUT outputs are compared
//   with it. Table vectors and hand sequences add fixed expected values.
// ----------------------------------------------------------------------------
module tb_color_poly_correct;

  localparam int PIX_W     = 8;
  localparam int COORD_W   = 10;
  localparam int COEF_W    = 24;
  localparam int FRAC_BITS = 16;
  localparam int ACC_W     = 56;
  localparam int AMB       = 0;
  localparam int ONE       = 1 << FRAC_BITS;

  // Exponents of R, G, B for each of the 18 terms.
  localparam int PR [18] = '{3,0,0,2,1,0,0,1,2,2,0,0,1,0,1,1,0,0};
  localparam int PG [18] = '{0,3,0,1,2,2,1,0,0,0,2,0,1,1,0,0,1,0};
  localparam int PB [18] = '{0,0,3,0,0,1,2,2,1,0,0,2,0,1,1,0,0,1};

  logic clk_25 = 1'b0;
  logic reset  = 1'b0;
  always #20 clk_25 = ~clk_25;

  color_poly_correct_if #(.PIX_W(PIX_W), .COORD_W(COORD_W), .COEF_W(COEF_W)) bus ();

  color_poly_correct #(
    .PIX_W(PIX_W), .COORD_W(COORD_W), .COEF_W(COEF_W),
    .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W), .AMB_SHIFT(10'sd0)
  ) dut (
    .clk_25(clk_25),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { bit v; int x, y, r, g, b; } slot_t;
  typedef struct { int x, y, r, g, b; } pix_t;
  typedef struct { int x, y, r, g, b, er, eg, eb; } vec_t;

  int     tests = 0;
  int     fails = 0;
  slot_t  slot [3];
  longint mbank [2][54];
  bit     mact, mpend;
  pix_t   obs [$];
  bit     seen_valid, seen_ready;
  vec_t   id_vec [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_ch(input int bk, input int ch, input int r, input int g, input int b);
    longint acc, tv, v;
    acc = 0;
    for (int t = 0; t < 18; t++) begin
      tv = 1;
      for (int k = 0; k < PR[t]; k++) tv = tv * r;
      for (int k = 0; k < PG[t]; k++) tv = tv * g;
      for (int k = 0; k < PB[t]; k++) tv = tv * b;
      acc = acc + mbank[bk][ch*18 + t] * tv;
    end
    v = ((acc + (longint'(1) << (FRAC_BITS - 1))) >>> FRAC_BITS) + AMB;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) slot[i].v = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 54; i++)
        mbank[b][i] = (i == 15 || i == 34 || i == 53) ? longint'(ONE) : 0;
    mact  = 1'b0;
    mpend = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; checks, advances the
  // model, and returns at the next falling edge.
  task automatic step();
    bit adv, acc_b, zero, swap;
    int bk, r, g, b;
    #1;
    adv = bus.ready_i || !slot[2].v;
    seen_valid = bus.valid_o;
    seen_ready = bus.ready_o;
    check("ready_o", bus.ready_o, adv);
    check("valid_o", bus.valid_o, slot[2].v);
    check("commit_pending_o", bus.commit_pending_o, mpend);
    check("active_bank_o", bus.active_bank_o, mact);
    if (slot[2].v) begin
      check("x_o", bus.x_o, slot[2].x);
      check("y_o", bus.y_o, slot[2].y);
      check("red_o", bus.red_o, slot[2].r);
      check("green_o", bus.green_o, slot[2].g);
      check("blue_o", bus.blue_o, slot[2].b);
    end
    if (bus.valid_o && bus.ready_i)
      obs.push_back('{int'(bus.x_o), int'(bus.y_o), int'(bus.red_o), int'(bus.green_o), int'(bus.blue_o)});

    acc_b = bus.valid_i && adv;
    zero  = (bus.x_i == 0) && (bus.y_i == 0);
    swap  = acc_b && zero && mpend && !bus.coef_commit;
    bk    = swap ? int'(!mact) : int'(mact);
    if (adv) begin
      slot[2] = slot[1];
      slot[1] = slot[0];
      slot[0].v = bus.valid_i;
      if (bus.valid_i) begin
        r = bus.red_i; g = bus.green_i; b = bus.blue_i;
        slot[0].x = bus.x_i;
        slot[0].y = bus.y_i;
        slot[0].r = model_ch(bk, 0, r, g, b);
        slot[0].g = model_ch(bk, 1, r, g, b);
        slot[0].b = model_ch(bk, 2, r, g, b);
      end
    end
    if (bus.coef_we && !mpend && bus.coef_addr < 54)
      mbank[!mact][bus.coef_addr] = longint'($signed(bus.coef_data));
    if (swap) begin
      mact  = !mact;
      mpend = 1'b0;
    end else if (bus.coef_commit) begin
      mpend = 1'b1;
    end
    @(posedge clk_25);
    @(negedge clk_25);
  endtask

  task automatic idle_inputs();
    bus.valid_i = 1'b0; bus.ready_i = 1'b1;
    bus.x_i = '0; bus.y_i = '0;
    bus.red_i = '0; bus.green_i = '0; bus.blue_i = '0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0; bus.coef_commit = 1'b0;
  endtask

  task automatic beat(input int x, input int y, input int r, input int g, input int b);
    bus.valid_i = 1'b1;
    bus.x_i = COORD_W'(x); bus.y_i = COORD_W'(y);
    bus.red_i = PIX_W'(r); bus.green_i = PIX_W'(g); bus.blue_i = PIX_W'(b);
    step();
    bus.valid_i = 1'b0;
  endtask

  task automatic wr(input int addr, input int data);
    bus.coef_we = 1'b1; bus.coef_addr = 6'(addr); bus.coef_data = COEF_W'(data);
    step();
    bus.coef_we = 1'b0;
  endtask

  task automatic commit();
    bus.coef_commit = 1'b1;
    step();
    bus.coef_commit = 1'b0;
  endtask

  task automatic flush(input int n);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_obs(input string name, input int i, input int r, input int g, input int b);
    if (obs.size() > i) begin
      check({name, "_r"}, obs[i].r, r);
      check({name, "_g"}, obs[i].g, g);
      check({name, "_b"}, obs[i].b, b);
    end else begin
      check({name, "_present"}, obs.size(), i + 1);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, idx, stalls;
    bit pred;

    id_vec[0] = '{1, 0,  10, 200, 255,  10, 200, 255};
    id_vec[1] = '{2, 0,   0,   0,   0,   0,   0,   0};
    id_vec[2] = '{3, 0, 255, 255, 255, 255, 255, 255};
    id_vec[3] = '{4, 9,   1, 128,  77,   1, 128,  77};
    id_vec[4] = '{1023, 1023, 254, 3, 100, 254, 3, 100};

    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk_25);
    #1;
    check("rst_valid_o", bus.valid_o, 0);
    check("rst_red_o", bus.red_o, 0);
    check("rst_x_o", bus.x_o, 0);
    check("rst_pending", bus.commit_pending_o, 0);
    check("rst_bank", bus.active_bank_o, 0);
    @(negedge clk_25);
    reset = 1'b1;
    @(negedge clk_25);

    // Identity vectors, back-to-back.
    obs.delete();
    for (int i = 0; i < 5; i++)
      beat(id_vec[i].x, id_vec[i].y, id_vec[i].r, id_vec[i].g, id_vec[i].b);
    flush(5);
    check("id_count", obs.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check_obs("id_vec", i, id_vec[i].er, id_vec[i].eg, id_vec[i].eb);
      if (obs.size() > i) begin
        check("id_x", obs[i].x, id_vec[i].x);
        check("id_y", obs[i].y, id_vec[i].y);
      end
    end

    // Latency of a single beat.
    beat(7, 3, 1, 2, 3);
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (seen_valid && lat == 0) lat = i;
    end
    check("latency", lat, 3);

    // Saturation: R channel = R^3 only, on bank 1.
    obs.delete();
    wr(15, 0);
    wr(0, ONE);
    commit();
    beat(0, 0, 100, 0, 0);
    beat(1, 0, 6, 0, 0);
    flush(4);
    check_obs("sat_100", 0, 255, 0, 0);
    check_obs("sat_6", 1, 216, 0, 0);
    check("sat_bank", bus.active_bank_o, 1);

    // Rounding and negative clamp, on bank 0.
    obs.delete();
    wr(53, -ONE);
    wr(15, ONE / 2);
    commit();
    beat(0, 0, 3, 9, 50);
    flush(4);
    check_obs("round_neg", 0, 2, 9, 0);

    // Bank swap timing: bank 1 gets green x2; old bank 0 keeps 0.5R / -B.
    obs.delete();
    wr(34, 2 * ONE);
    commit();
    check("swap_pending_set", bus.commit_pending_o, 1);
    beat(5, 7, 4, 20, 30);
    wr(34, 3 * ONE);
    check("swap_pending_hold", bus.commit_pending_o, 1);
    check("swap_bank_before", bus.active_bank_o, 0);
    beat(0, 0, 4, 20, 30);
    check("swap_bank_after", bus.active_bank_o, 1);
    check("swap_pending_clear", bus.commit_pending_o, 0);
    flush(4);
    check_obs("swap_old", 0, 2, 20, 0);
    check_obs("swap_new", 1, 64, 40, 30);

    // Backpressure: 6 beats, ready_i low for cycles 4..7.
    obs.delete();
    idx = 0;
    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      bus.ready_i = !(c >= 4 && c < 8);
      if (idx < 6) begin
        bus.valid_i = 1'b1;
        bus.x_i = COORD_W'(10 + idx); bus.y_i = COORD_W'(2);
        bus.red_i = PIX_W'(idx + 1); bus.green_i = PIX_W'(idx * 10); bus.blue_i = PIX_W'(idx * 20);
      end else begin
        bus.valid_i = 1'b0;
      end
      pred = bus.valid_i && (bus.ready_i || !slot[2].v);
      step();
      if (!seen_ready) stalls++;
      if (pred) idx++;
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    check("bp_count", obs.size(), 6);
    check("bp_stalls", stalls, 4);
    for (int i = 0; i < 6; i++)
      if (obs.size() > i) check("bp_order", obs[i].x, 10 + i);

    // Reset with beats in flight and a commit pending.
    commit();
    beat(1, 1, 9, 9, 9);
    beat(2, 1, 9, 9, 9);
    beat(3, 1, 9, 9, 9);
    reset = 1'b0;
    #1;
    check("mrst_valid_o", bus.valid_o, 0);
    check("mrst_pending", bus.commit_pending_o, 0);
    check("mrst_bank", bus.active_bank_o, 0);
    check("mrst_red_o", bus.red_o, 0);
    model_reset();
    @(negedge clk_25);
    @(negedge clk_25);
    reset = 1'b1;
    @(negedge clk_25);
    obs.delete();
    beat(3, 4, 77, 88, 99);
    commit();
    beat(0, 0, 11, 22, 33);
    flush(5);
    check_obs("mrst_bank0", 0, 77, 88, 99);
    check_obs("mrst_bank1", 1, 11, 22, 33);
    check("mrst_swap", bus.active_bank_o, 1);

    // Randomised traffic against the model.
    for (int c = 0; c < 500; c++) begin
      bus.valid_i   = ($urandom_range(0, 9) < 7);
      bus.ready_i   = ($urandom_range(0, 3) != 0);
      bus.x_i       = COORD_W'($urandom_range(0, 3));
      bus.y_i       = COORD_W'($urandom_range(0, 3));
      bus.red_i     = PIX_W'($urandom_range(0, 255));
      bus.green_i   = PIX_W'($urandom_range(0, 255));
      bus.blue_i    = PIX_W'($urandom_range(0, 255));
      bus.coef_we   = ($urandom_range(0, 9) == 0);
      bus.coef_addr = 6'($urandom_range(0, 63));
      bus.coef_data = COEF_W'(int'($urandom_range(0, 2 * 131072)) - 131072);
      bus.coef_commit = ($urandom_range(0, 29) == 0);
      step();
    end
    idle_inputs();
    flush(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
